// File: rtl/key_gen_inv.sv
// Inverse S-AES key schedule: loads K2 byte-serially, then emits K2, K1, K0 on a valid/ready port.
// Optional forward self-check of each backward step is enabled with `define KEYGEN_INV_CHECK_EN.

module s_box (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  always_comb begin
    o_nib = 4'h0;
    case (i_nib)
      4'h0: o_nib = 4'h9;
      4'h1: o_nib = 4'h4;
      4'h2: o_nib = 4'hA;
      4'h3: o_nib = 4'hB;
      4'h4: o_nib = 4'hD;
      4'h5: o_nib = 4'h1;
      4'h6: o_nib = 4'h8;
      4'h7: o_nib = 4'h5;
      4'h8: o_nib = 4'h6;
      4'h9: o_nib = 4'h2;
      4'hA: o_nib = 4'h0;
      4'hB: o_nib = 4'h3;
      4'hC: o_nib = 4'hC;
      4'hD: o_nib = 4'hE;
      4'hE: o_nib = 4'hF;
      4'hF: o_nib = 4'h7;
      default: o_nib = 4'h0;
    endcase
  end
endmodule

`ifdef KEYGEN_INV_CHECK_EN
module key_gen (
  input  logic [15:0] input_key,
  input  logic [7:0]  round_constant,
  output logic [15:0] output_key
);
  logic [3:0] w_s_lo;
  logic [3:0] w_s_hi;
  logic [7:0] w_g;
  logic [7:0] w_hi;

  s_box u_sbox_lo (.i_nib(input_key[3:0]), .o_nib(w_s_lo));
  s_box u_sbox_hi (.i_nib(input_key[7:4]), .o_nib(w_s_hi));

  always_comb begin
    w_g        = {w_s_lo ^ round_constant[7:4], w_s_hi ^ round_constant[3:0]};
    w_hi       = input_key[15:8] ^ w_g;
    output_key = {w_hi, input_key[7:0] ^ w_hi};
  end
endmodule
`endif

module key_gen_inv #(
  parameter logic [7:0] RC1 = 8'h80,
  parameter logic [7:0] RC2 = 8'h30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  key_byte,
  input  logic        key_byte_valid,
  output logic        load_ready,
  output logic [15:0] rk_out,
  output logic [1:0]  rk_idx,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        done,
  output logic        chk_err
);

  typedef enum logic [1:0] {S_HI, S_LO, S_OUT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_rk_out;
  logic [1:0]  r_rk_idx;
  logic        r_rk_valid;
  logic        r_done;

  logic [7:0]  w_prev_lo;
  logic [7:0]  w_prev_hi;
  logic [15:0] w_prev_key;
  logic [3:0]  w_s_lo;
  logic [3:0]  w_s_hi;
  logic [7:0]  w_rc;
  logic [7:0]  w_g;
  logic        w_accept;
  logic        w_hs;

  // Undo one forward step: lo is recovered first, then g() is re-run on it to strip hi.
  s_box u_sbox_lo (.i_nib(w_prev_lo[3:0]), .o_nib(w_s_lo));
  s_box u_sbox_hi (.i_nib(w_prev_lo[7:4]), .o_nib(w_s_hi));

  always_comb begin
    w_prev_lo  = r_rk_out[7:0] ^ r_rk_out[15:8];
    w_rc       = (r_rk_idx == 2'd2) ? RC2 : RC1;
    w_g        = {w_s_lo ^ w_rc[7:4], w_s_hi ^ w_rc[3:0]};
    w_prev_hi  = r_rk_out[15:8] ^ w_g;
    w_prev_key = {w_prev_hi, w_prev_lo};
  end

  always_comb begin
    w_accept = load_ready & key_byte_valid;
    w_hs     = r_rk_valid & rk_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HI;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HI:    if (key_byte_valid) w_state_nxt = S_LO;
      S_LO:    if (key_byte_valid) w_state_nxt = S_OUT;
      S_OUT:   if (w_hs && (r_rk_idx == 2'd0)) w_state_nxt = S_HI;
      default: w_state_nxt = S_HI;
    endcase
  end

  always_comb begin
    load_ready = (r_state != S_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_out   <= '0;
      r_rk_idx   <= '0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_HI: begin
          if (w_accept) r_rk_out[15:8] <= key_byte;
        end
        S_LO: begin
          if (w_accept) begin
            r_rk_out[7:0] <= key_byte;
            r_rk_idx      <= 2'd2;
            r_rk_valid    <= 1'b1;
          end
        end
        S_OUT: begin
          if (w_hs) begin
            if (r_rk_idx != 2'd0) begin
              r_rk_out <= w_prev_key;
              r_rk_idx <= r_rk_idx - 2'd1;
            end else begin
              r_rk_valid <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rk_out   = r_rk_out;
    rk_idx   = r_rk_idx;
    rk_valid = r_rk_valid;
    done     = r_done;
  end

`ifdef KEYGEN_INV_CHECK_EN
  logic [15:0] w_fwd_key;
  logic        r_chk_err;

  key_gen u_key_gen (
    .input_key      (w_prev_key),
    .round_constant (w_rc),
    .output_key     (w_fwd_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_chk_err <= 1'b0;
    else if ((r_state == S_OUT) && w_hs && (r_rk_idx != 2'd0) && (w_fwd_key != r_rk_out))
      r_chk_err <= 1'b1;
  end

  always_comb chk_err = r_chk_err;
`else
  always_comb chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_key_gen_inv.sv
// Self-checking bench for key_gen_inv: directed vectors, stalls, mid-run reset, back-to-back and random keys.
// Expected keys come from solving the forward S-AES key expansion backwards in plain arithmetic.

module tb_key_gen_inv;

  logic        clk;
  logic        rst_n;
  logic [7:0]  key_byte;
  logic        key_byte_valid;
  logic        load_ready;
  logic [15:0] rk_out;
  logic [1:0]  rk_idx;
  logic        rk_valid;
  logic        rk_ready;
  logic        done;
  logic        chk_err;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] SBOX_TAB = 64'h7FEC3026581DBA49;
  localparam logic [7:0]  M_RC1 = 8'h80;
  localparam logic [7:0]  M_RC2 = 8'h30;

  key_gen_inv dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_byte       (key_byte),
    .key_byte_valid (key_byte_valid),
    .load_ready     (load_ready),
    .rk_out         (rk_out),
    .rk_idx         (rk_idx),
    .rk_valid       (rk_valid),
    .rk_ready       (rk_ready),
    .done           (done),
    .chk_err        (chk_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_TAB;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [7:0] m_g(input logic [7:0] w, input logic [7:0] rc);
    logic [7:0] sw;
    sw = {w[3:0], w[7:4]};
    return {m_sbox(sw[7:4]), m_sbox(sw[3:0])} ^ rc;
  endfunction

  // Forward expansion is hi' = hi ^ g(lo), lo' = lo ^ hi'; solve it for (hi, lo).
  function automatic logic [15:0] m_prev(input logic [15:0] k, input logic [7:0] rc);
    logic [7:0] lo;
    lo = k[7:0] ^ k[15:8];
    return {k[15:8] ^ m_g(lo, rc), lo};
  endfunction

  // Expected delivery order indexed by handshake count: K2, K1, K0.
  function automatic logic [47:0] m_sched(input logic [15:0] k2);
    logic [15:0] k1;
    k1 = m_prev(k2, M_RC2);
    return {k2, k1, m_prev(k1, M_RC1)};
  endfunction

  function automatic logic [15:0] pick(input logic [47:0] s, input int n);
    return s[47 - 16*n -: 16];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [15:0] k);
    key_byte_valid = 1'b1;
    key_byte       = k[15:8];
    tick();
    key_byte       = k[7:0];
    tick();
    key_byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_byte = 8'h00;
    key_byte_valid = 1'b0;
    rk_ready = 1'b0;
    #3;
    total++;
    if (load_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 16'h0000 ||
        rk_idx !== 2'd0 || done !== 1'b0 || chk_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: lr=%b v=%b out=%h idx=%0d done=%b err=%b, want lr=1 v=0 out=0000 idx=0 done=0 err=0",
               load_ready, rk_valid, rk_out, rk_idx, done, chk_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (load_ready !== 1'b1 || rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: lr=%b v=%b, want lr=1 v=0", load_ready, rk_valid);
    end
  endtask

  task automatic test_vector;
    logic [15:0] want [3];
    want[0] = 16'h7651; want[1] = 16'h1C27; want[2] = 16'hA73B;
    rk_ready = 1'b1;
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL vec_lr_hi: got %b want 1", load_ready);
    end
    key_byte_valid = 1'b1; key_byte = 8'h76;
    tick();
    total++;
    if (load_ready !== 1'b1 || rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL vec_lr_lo: lr=%b v=%b want lr=1 v=0", load_ready, rk_valid);
    end
    key_byte = 8'h51;
    tick();
    key_byte_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      total++;
      if (rk_valid !== 1'b1 || rk_out !== want[n] || rk_idx !== 2'(2 - n) || load_ready !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL vec_key%0d: v=%b out=%h idx=%0d lr=%b done=%b, want v=1 out=%h idx=%0d lr=0 done=0",
                 n, rk_valid, rk_out, rk_idx, load_ready, done, want[n], 2 - n);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || load_ready !== 1'b1 || rk_out !== 16'hA73B) begin
      bad++;
      $display("FAIL vec_done: done=%b v=%b lr=%b out=%h, want done=1 v=0 lr=1 out=a73b",
               done, rk_valid, load_ready, rk_out);
    end
    tick();
    total++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL vec_done_pulse: done=%b v=%b, want done=0 v=0", done, rk_valid);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_stall;
    logic [47:0] s;
    int n;
    logic pr;
    s = m_sched(16'h7651);
    rk_ready = 1'b0;
    load_key(16'h7651);
    n = 0;
    pr = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      total++;
      if (rk_valid !== 1'b1 || rk_out !== pick(s, n) || rk_idx !== 2'(2 - n) || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_key%0d: v=%b out=%h idx=%0d lr=%b, want v=1 out=%h idx=%0d lr=0",
                 n, rk_valid, rk_out, rk_idx, load_ready, pick(s, n), 2 - n);
      end
      pr = ~pr;
      rk_ready = pr;
      key_byte = 8'hFF;
      key_byte_valid = !(pr && n == 2);
      if (pr) n++;
      tick();
    end
    rk_ready = 1'b0;
    key_byte_valid = 1'b0;
    total++;
    if (n != 3 || done !== 1'b1 || rk_valid !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_end: handshakes=%0d done=%b v=%b lr=%b, want 3 done=1 v=0 lr=1",
               n, done, rk_valid, load_ready);
    end
    tick();
    total++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_after: done=%b v=%b, want done=0 v=0", done, rk_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [47:0] s;
    rk_ready = 1'b1;
    load_key(16'h7651);
    tick();
    rk_ready = 1'b0;
    total++;
    if (rk_idx !== 2'd1 || rk_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre: idx=%0d v=%b want idx=1 v=1", rk_idx, rk_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 16'h0000 || rk_idx !== 2'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async: lr=%b v=%b out=%h idx=%0d done=%b, want lr=1 v=0 out=0000 idx=0 done=0",
               load_ready, rk_valid, rk_out, rk_idx, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (rk_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rmid_idle: v=%b done=%b, want v=0 done=0", rk_valid, done);
    end
    s = m_sched(16'h0000);
    rk_ready = 1'b1;
    load_key(16'h0000);
    for (int n = 0; n < 3; n++) begin
      total++;
      if (rk_valid !== 1'b1 || rk_out !== pick(s, n) || rk_idx !== 2'(2 - n)) begin
        bad++;
        $display("FAIL rmid_key%0d: v=%b out=%h idx=%0d, want v=1 out=%h idx=%0d",
                 n, rk_valid, rk_out, rk_idx, pick(s, n), 2 - n);
      end
      tick();
    end
    rk_ready = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL rmid_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [15:0] ka, kb;
    logic [47:0] sa, sb;
    ka = 16'($urandom);
    kb = 16'($urandom);
    sa = m_sched(ka);
    sb = m_sched(kb);
    rk_ready = 1'b1;
    load_key(ka);
    for (int n = 0; n < 3; n++) begin
      total++;
      if (rk_valid !== 1'b1 || rk_out !== pick(sa, n) || rk_idx !== 2'(2 - n)) begin
        bad++;
        $display("FAIL b2b_a%0d: v=%b out=%h idx=%0d, want v=1 out=%h idx=%0d",
                 n, rk_valid, rk_out, rk_idx, pick(sa, n), 2 - n);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done: done=%b lr=%b want done=1 lr=1", done, load_ready);
    end
    load_key(kb);
    for (int n = 0; n < 3; n++) begin
      total++;
      if (rk_valid !== 1'b1 || rk_out !== pick(sb, n) || rk_idx !== 2'(2 - n)) begin
        bad++;
        $display("FAIL b2b_b%0d: v=%b out=%h idx=%0d, want v=1 out=%h idx=%0d",
                 n, rk_valid, rk_out, rk_idx, pick(sb, n), 2 - n);
      end
      tick();
    end
    rk_ready = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done2: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_random;
    logic [15:0] k;
    logic [47:0] s;
    int n;
    int dones;
    for (int t = 0; t < 8; t++) begin
      k = 16'($urandom);
      s = m_sched(k);
      rk_ready = 1'b0;
      for (int w = $urandom_range(0, 2); w > 0; w--) tick();
      load_key(k);
      n = 0;
      dones = 0;
      for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
        total++;
        if (rk_valid !== 1'b1 || rk_out !== pick(s, n) || rk_idx !== 2'(2 - n) || chk_err !== 1'b0) begin
          bad++;
          $display("FAIL rnd%0d_key%0d: v=%b out=%h idx=%0d err=%b, want v=1 out=%h idx=%0d err=0",
                   t, n, rk_valid, rk_out, rk_idx, chk_err, pick(s, n), 2 - n);
        end
        rk_ready = ($urandom_range(0, 2) != 0);
        if (rk_ready) n++;
        tick();
      end
      rk_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (done === 1'b1) dones++;
        tick();
      end
      total++;
      if (n != 3 || dones != 1) begin
        bad++;
        $display("FAIL rnd%0d_end: handshakes=%0d done_pulses=%0d, want 3 and 1", t, n, dones);
      end
    end
  endtask

`ifdef KEYGEN_INV_CHECK_EN
  task automatic test_check;
    logic [7:0] v;
    rk_ready = 1'b0;
    load_key(16'($urandom));
    v = dut.w_prev_hi;
    force dut.w_prev_hi = ~v;
    rk_ready = 1'b1;
    tick();
    release dut.w_prev_hi;
    rk_ready = 1'b1;
    tick();
    tick();
    rk_ready = 1'b0;
    tick();
    total++;
    if (chk_err !== 1'b1) begin
      bad++;
      $display("FAIL chk_set: got %b want 1", chk_err);
    end
    tick();
    tick();
    total++;
    if (chk_err !== 1'b1) begin
      bad++;
      $display("FAIL chk_sticky: got %b want 1", chk_err);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (chk_err !== 1'b0) begin
      bad++;
      $display("FAIL chk_clear: got %b want 0", chk_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vector();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef KEYGEN_INV_CHECK_EN
    test_check();
`endif
    total++;
    if (chk_err !== 1'b0) begin
      bad++;
      $display("FAIL chk_final: got %b want 0", chk_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
